// File: rtl/riscv_pkg.sv
// Shared front-end constants and types used by the fetch unit and its queues.
package riscv_pkg;

  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO with flush, occupancy count and registered head.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ifu_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full queue is accepted only when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: sequential PC generation, in-order request tagging and a
// credit-limited fetch queue toward decode. Macro IFU_ALIGN_CHK_EN adds misaligned-redirect halting.
module ifu_fetch #(
  parameter int unsigned INST_WIDTH = riscv_pkg::INST_WIDTH,
  parameter int unsigned ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = riscv_pkg::RESET_PC,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req_vld,
  input  logic                  imem_req_rdy,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_vld,
  input  logic [INST_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_vld,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  dec_stall,
`ifdef IFU_ALIGN_CHK_EN
  output logic                  ifu_misalign,
`endif
  output logic                  ifu_vld,
  output logic [INST_WIDTH-1:0] ifu_inst,
  output logic [ADDR_WIDTH-1:0] ifu_pc
);

  import riscv_pkg::*;

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned FW = INST_WIDTH + ADDR_WIDTH;

  // Handshakes: a transfer happens in any cycle where valid and ready are both high at the
  // rising edge; imem responses are never back-pressured; decode pops when ifu_vld && !dec_stall.
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, redir_pc;
  logic [CW-1:0]         out_q, out_d, drop_q, drop_d;
  logic [CW-1:0]         fq_count, tag_count;
  logic [CW:0]           credit_used;
  logic [ADDR_WIDTH-1:0] tag_head;
  logic [FW-1:0]         fq_head;
  logic                  req_fire, rsp_take, rsp_keep, pop_fire, fetch_hold;

`ifdef IFU_ALIGN_CHK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect_vld) misalign_d = (redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end

  assign redir_pc     = redirect_pc;
  assign fetch_hold   = misalign_q;
  assign ifu_misalign = misalign_q;
`else
  assign redir_pc   = redirect_pc & ~ADDR_WIDTH'(3);
  assign fetch_hold = 1'b0;
`endif

  // Every request in flight or buffered holds a queue slot, so the fetch queue cannot overflow.
  assign credit_used  = {1'b0, out_q} + {1'b0, fq_count};
  assign imem_req_vld = rst_n && !redirect_vld && !fetch_hold &&
                        (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_req_addr = pc_q;

  assign req_fire = imem_req_vld && imem_req_rdy;
  assign rsp_take = imem_rsp_vld && (out_q != '0);
  assign rsp_keep = rsp_take && (drop_q == '0) && (tag_count != '0);
  assign pop_fire = ifu_vld && !dec_stall && !redirect_vld;

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (redirect_vld) begin
      // Nothing issues this cycle, so everything still in flight afterwards is stale.
      pc_d   = redir_pc;
      out_d  = out_q - CW'(rsp_take);
      drop_d = out_q - CW'(rsp_take);
    end else begin
      if (req_fire) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      out_d = out_q + CW'(req_fire) - CW'(rsp_take);
      if (rsp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  ifu_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (FQ_DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_keep && !redirect_vld),
    .flush_i (redirect_vld),
    .count_o (tag_count),
    .head_o  (tag_head)
  );

  ifu_fifo #(
    .WIDTH (FW),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_keep && !redirect_vld),
    .data_i  ({imem_rsp_data, tag_head}),
    .pop_i   (pop_fire),
    .flush_i (redirect_vld),
    .count_o (fq_count),
    .head_o  (fq_head)
  );

  assign ifu_vld  = (fq_count != '0);
  assign ifu_inst = ifu_vld ? fq_head[FW-1 -: INST_WIDTH] : '0;
  assign ifu_pc   = ifu_vld ? fq_head[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: in-order memory model with random latency and a program-order scoreboard.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_vld;
  logic        imem_req_rdy;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_vld;
  logic [31:0] imem_rsp_data;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        dec_stall;
  logic        ifu_vld;
  logic [31:0] ifu_inst;
  logic [31:0] ifu_pc;
`ifdef IFU_ALIGN_CHK_EN
  logic        ifu_misalign;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ifu_fetch #(
    .INST_WIDTH (32),
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0100),
    .FQ_DEPTH   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_vld  (imem_req_vld),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_vld  (imem_rsp_vld),
    .imem_rsp_data (imem_rsp_data),
    .redirect_vld  (redirect_vld),
    .redirect_pc   (redirect_pc),
    .dec_stall     (dec_stall),
`ifdef IFU_ALIGN_CHK_EN
    .ifu_misalign  (ifu_misalign),
`endif
    .ifu_vld       (ifu_vld),
    .ifu_inst      (ifu_inst),
    .ifu_pc        (ifu_pc)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          last_due;
  int          lat_min, lat_max;
  logic [31:0] next_req_pc;
  int          fired, consumed;
  bit          prev_redir, saw_zero;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  function automatic logic [31:0] redir_target(input logic [31:0] a);
`ifdef IFU_ALIGN_CHK_EN
    return a;
`else
    return a & ~32'h3;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    last_due    = 0;
    next_req_pc = 32'h0000_0100;
    fired       = 0;
    consumed    = 0;
    prev_redir  = 1'b0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input bit stall, input bit rdy, input bit redir, input logic [31:0] rpc);
    int lat;
    logic [31:0] exp_pc;
    @(posedge clk);
    #1;
    cyc++;
    rst_n        = 1'b1;
    dec_stall    = stall;
    imem_req_rdy = rdy;
    redirect_vld = redir;
    redirect_pc  = rpc;
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_vld  = 1'b1;
      imem_rsp_data = inst_of(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_vld  = 1'b0;
      imem_rsp_data = $urandom;
    end
    @(negedge clk);
    if (prev_redir) begin
      n_cmp++;
      if (ifu_vld !== 1'b0) begin
        n_err++;
        $display("FAIL vld_after_redirect: got %b want 0 (cyc %0d)", ifu_vld, cyc);
      end
    end
    if (redir) begin
      n_cmp++;
      if (imem_req_vld !== 1'b0) begin
        n_err++;
        $display("FAIL req_in_redirect: got %b want 0 (cyc %0d)", imem_req_vld, cyc);
      end
      exp_q.delete();
      next_req_pc = redir_target(rpc);
    end else begin
      if (imem_req_vld === 1'b1) begin
        n_cmp++;
        if (imem_req_addr !== next_req_pc) begin
          n_err++;
          $display("FAIL req_addr: got %h want %h (cyc %0d)", imem_req_addr, next_req_pc, cyc);
        end
        if (rdy) begin
          lat = $urandom_range(lat_max, lat_min);
          last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
          mem_addr_q.push_back(imem_req_addr);
          mem_due_q.push_back(last_due);
          exp_q.push_back(next_req_pc);
          next_req_pc = next_req_pc + 32'd4;
          fired++;
          n_cmp++;
          if (exp_q.size() > 4) begin
            n_err++;
            $display("FAIL credit: live %0d want <= 4 (cyc %0d)", exp_q.size(), cyc);
          end
        end
      end
      if (ifu_vld === 1'b1 && !stall) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL consume_unexpected: got pc %h want none (cyc %0d)", ifu_pc, cyc);
        end else begin
          exp_pc = exp_q.pop_front();
          if (ifu_pc !== exp_pc || ifu_inst !== inst_of(exp_pc)) begin
            n_err++;
            $display("FAIL consume: got %h/%h want %h/%h (cyc %0d)",
                     ifu_pc, ifu_inst, exp_pc, inst_of(exp_pc), cyc);
          end
          if (exp_pc == 32'h0) saw_zero = 1'b1;
        end
        consumed++;
      end
    end
    prev_redir = redir;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; imem_req_rdy = 1'b1; imem_rsp_vld = 1'b0; imem_rsp_data = '0;
    redirect_vld = 1'b0; redirect_pc = '0; dec_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (imem_req_vld !== 1'b0 || ifu_vld !== 1'b0 || ifu_inst !== 32'h0 || ifu_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got req %b vld %b inst %h pc %h want 0 0 0 0",
               imem_req_vld, ifu_vld, ifu_inst, ifu_pc);
    end
`ifdef IFU_ALIGN_CHK_EN
    n_cmp++;
    if (ifu_misalign !== 1'b0) begin
      n_err++;
      $display("FAIL reset_misalign: got %b want 0", ifu_misalign);
    end
`endif
    model_reset();
    lat_min = 1; lat_max = 1;
    step(0, 1, 0, 0);
    n_cmp++;
    if (fired != 1) begin
      n_err++;
      $display("FAIL first_request: got %0d fires want 1", fired);
    end
  endtask

  task automatic test_stream();
    consumed = 0;
    repeat (30) step(0, 1, 0, 0);
    n_cmp++;
    if (consumed != 29) begin
      n_err++;
      $display("FAIL throughput: got %0d consumed want 29", consumed);
    end
  endtask

  task automatic test_stall();
    step(0, 1, 1, 32'h400);
    fired = 0; consumed = 0;
    repeat (10) step(1, 1, 0, 0);
    n_cmp++;
    if (fired != 4) begin
      n_err++;
      $display("FAIL stall_fires: got %0d want 4", fired);
    end
    n_cmp++;
    if (ifu_vld !== 1'b1 || imem_req_vld !== 1'b0) begin
      n_err++;
      $display("FAIL stall_state: got vld %b req %b want 1 0", ifu_vld, imem_req_vld);
    end
    repeat (6) step(0, 1, 0, 0);
    n_cmp++;
    if (consumed < 4) begin
      n_err++;
      $display("FAIL stall_drain: got %0d consumed want >= 4", consumed);
    end
  endtask

  task automatic test_redirect_latency();
    lat_min = 3; lat_max = 3;
    repeat (10) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h200);
    consumed = 0;
    repeat (14) step(0, 1, 0, 0);
    n_cmp++;
    if (consumed < 4) begin
      n_err++;
      $display("FAIL redirect_latency_progress: got %0d consumed want >= 4", consumed);
    end
  endtask

  task automatic test_back_to_back();
    lat_min = 1; lat_max = 1;
    repeat (8) step(0, 1, 0, 0);
    step(0, 1, 1, 32'h600);
    n_cmp++;
    if (ifu_vld !== 1'b1 || imem_rsp_vld !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_setup: got vld %b rsp %b want 1 1", ifu_vld, imem_rsp_vld);
    end
    step(0, 1, 1, 32'h700);
    consumed = 0;
    repeat (10) step(0, 1, 0, 0);
    n_cmp++;
    if (consumed < 6) begin
      n_err++;
      $display("FAIL back_to_back_progress: got %0d consumed want >= 6", consumed);
    end
  endtask

  task automatic test_wrap();
    lat_min = 1; lat_max = 3;
    saw_zero = 1'b0;
    step(0, 1, 1, 32'hFFFF_FFF0);
    for (int i = 0; i < 60; i++)
      step($urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1, 0, 0);
    n_cmp++;
    if (saw_zero !== 1'b1) begin
      n_err++;
      $display("FAIL wrap: got saw_zero %b want 1", saw_zero);
    end
  endtask

  task automatic test_random();
    logic [31:0] rpc;
    lat_min = 1; lat_max = 4;
    consumed = 0;
    for (int i = 0; i < 400; i++) begin
      rpc = $urandom;
`ifdef IFU_ALIGN_CHK_EN
      rpc = rpc & ~32'h3;
`endif
      step($urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0, $urandom_range(19, 0) == 0, rpc);
    end
    n_cmp++;
    if (consumed < 60) begin
      n_err++;
      $display("FAIL random_progress: got %0d consumed want >= 60", consumed);
    end
  endtask

`ifdef IFU_ALIGN_CHK_EN
  task automatic test_misalign();
    lat_min = 1; lat_max = 2;
    step(0, 1, 1, 32'h202);
    fired = 0;
    repeat (6) step(0, 1, 0, 0);
    n_cmp++;
    if (ifu_misalign !== 1'b1 || imem_req_vld !== 1'b0 || fired != 0) begin
      n_err++;
      $display("FAIL misalign_halt: got flag %b req %b fires %0d want 1 0 0",
               ifu_misalign, imem_req_vld, fired);
    end
    step(0, 1, 1, 32'h300);
    consumed = 0;
    repeat (10) step(0, 1, 0, 0);
    n_cmp++;
    if (ifu_misalign !== 1'b0 || consumed < 4) begin
      n_err++;
      $display("FAIL misalign_resume: got flag %b consumed %0d want 0 >=4", ifu_misalign, consumed);
    end
  endtask
`endif

  task automatic test_mid_reset();
    lat_min = 1; lat_max = 2;
    repeat (6) step(0, 1, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_vld !== 1'b0 || ifu_vld !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got req %b vld %b want 0 0", imem_req_vld, ifu_vld);
    end
    imem_rsp_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step(0, 1, 0, 0);
    n_cmp++;
    if (fired != 1) begin
      n_err++;
      $display("FAIL reset_restart: got %0d fires want 1", fired);
    end
    repeat (10) step(0, 1, 0, 0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_back_to_back();
    test_wrap();
`ifdef IFU_ALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: generates sequential fetch addresses, issues requests to the instruction memory port, buffers returned instructions in a small in-order queue, and drives the `ifu_vld`/`ifu_inst` pair that feeds the decode stage. It sits between the instruction memory and decode. It supports a backpressure stall from decode and a single-cycle redirect (branch/exception) that flushes all fetched and in-flight work.

## Interface
- `INST_WIDTH`, 32: instruction width.
- `ADDR_WIDTH`, 32: fetch address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `FQ_DEPTH`, 4: fetch queue entries (power of two, ≥2).
- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `imem_req_vld`  out  1  fetch request valid.
- `imem_req_rdy`  in  1  memory accepts the request.
- `imem_req_addr`  out  ADDR_WIDTH  fetch address (word aligned).
- `imem_rsp_vld`  in  1  response valid; responses are in order, latency ≥1 cycle, never stalled.
- `imem_rsp_data`  in  INST_WIDTH  fetched instruction.
- `redirect_vld`  in  1  redirect fetch.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address.
- `dec_stall`  in  1  decode cannot accept this cycle.
- `ifu_vld`  out  1  instruction valid to decode.
- `ifu_inst`  out  INST_WIDTH  instruction to decode.
- `ifu_pc`  out  ADDR_WIDTH  PC of `ifu_inst`.
- `ifu_misalign`  out  1  sticky misaligned-redirect flag (present only with the config macro).

## Operation
- State: `pc`; `outstanding` count (0..FQ_DEPTH); `drop` count (responses to discard); fetch queue of {inst, pc}; a pc-tag queue of FQ_DEPTH entries holding request addresses in issue order.
- Request issue: `imem_req_vld = !redirect_vld && (outstanding + fq_count) < FQ_DEPTH`. Handshake when `imem_req_vld && imem_req_rdy`: `pc <= pc + 4`, `outstanding++`, request address pushed to the tag queue.
- Response: on `imem_rsp_vld`, `outstanding--`; if `drop != 0`, `drop--` and the response is discarded; otherwise {`imem_rsp_data`, tag-queue head} is pushed into the fetch queue.
- Output: `ifu_vld = fq_count != 0`; `ifu_inst`/`ifu_pc` are taken from the fetch queue head. A pop occurs when `ifu_vld && !dec_stall`.
- Redirect (highest priority): fetch queue and tag queue are cleared; `pc <= redirect_pc`; `drop <= outstanding - (imem_rsp_vld ? 1 : 0) + drop`-adjusted, i.e. every request still in flight after this cycle is discarded. No request is issued in the redirect cycle. Any pop or push in the same cycle is void.
- Credit rule: `outstanding + fq_count ≤ FQ_DEPTH` at all times, so the queue can never overflow. Same-cycle push and pop on a full queue is legal.
- Address arithmetic: `pc + 4` wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset values: `imem_req_vld=0` while `rst_n` is low; after reset, `pc=RESET_PC`, counters=0, queues empty, `ifu_vld=0`, `ifu_inst=0`, `ifu_pc=0`, `ifu_misalign=0`.
- First request is presented in the first cycle after `rst_n` deasserts.
- A response accepted in cycle N produces `ifu_vld=1` in cycle N+1 (registered queue, no bypass).
- Redirect in cycle N: `ifu_vld=0` in N+1; the first request to `redirect_pc` is issued in N+1.
- Reset asserted mid-operation clears all state immediately. In-flight memory responses arriving after reset are the memory's responsibility and are not counted.
- Throughput: 1 instruction per cycle when `imem_req_rdy=1` and the pipeline is not stalled.

## Configuration
- `IFU_ALIGN_CHK_EN` defined: a redirect whose `redirect_pc[1:0] != 0` sets `ifu_misalign` (sticky) and halts request issue. A subsequent aligned redirect clears the flag and resumes fetching.
- Not defined: the `ifu_misalign` port is absent, and `redirect_pc[1:0]` is forced to 0.

## Structure
- Shared `riscv_pkg`: `INST_WIDTH`, `ADDR_WIDTH`, `RESET_PC`, and the typedef `fq_entry_t` {inst, pc}.
- Sub-module `ifu_fifo`: parameterized synchronous FIFO (push, pop, flush, count, head) with asynchronous active-low reset. It is instantiated twice, once for the fetch queue and once for the tag queue.

## Test plan
- Reset release with `RESET_PC=0x100`, `imem_req_rdy=1`, 1-cycle memory -> requests to 0x100, 0x104, 0x108…; `ifu_pc` follows the same sequence with 1 instruction per cycle.
- `dec_stall=1` for 10 cycles -> exactly FQ_DEPTH (4) requests are outstanding or buffered, with no more issued. After release, the 4 instructions drain in order, none lost.
- Memory latency 3 cycles with a redirect to 0x200 while 3 requests are in flight -> the 3 stale responses are dropped, the next `ifu_pc` is 0x200, and `ifu_vld=0` in the cycle after the redirect.
- Redirect in the same cycle as a pop and a response -> the queue is empty the next cycle, `drop` equals the remaining in-flight count, and no stale instruction reaches decode.
- `imem_req_rdy` toggled randomly with `pc` near 0xFFFF_FFFC -> the address wraps to 0x0 and the order is preserved.
- With `IFU_ALIGN_CHK_EN`: redirect to 0x202 -> `ifu_misalign=1` and `imem_req_vld=0`. A following redirect to 0x300 clears the flag and fetching resumes at 0x300.
